// File: rtl/dram_arb_pkg.sv
// Shared encodings for the data_ram arbiter: FSM states, owner ids,
// wait counter width and the RAM command constants.
// Latency: n/a (types and constants only). Backpressure: n/a.
package dram_arb_pkg;

  // Arbiter FSM: IDLE arbitrates freely, LOCK1 keeps port 1 as owner.
  typedef enum logic {
    IDLE  = 1'b0,
    LOCK1 = 1'b1
  } arb_state_t;

  // Owner identifiers held in last_owner.
  localparam logic OWNER_M0 = 1'b0;
  localparam logic OWNER_M1 = 1'b1;

  // Width of the CPU starvation counter (MAX_WAIT must fit, 1..15).
  localparam int WAIT_CNT_W = 4;

  // RAM command levels.
  localparam logic CHIP_ENABLE   = 1'b1;
  localparam logic CHIP_DISABLE  = 1'b0;
  localparam logic WRITE_ENABLE  = 1'b1;
  localparam logic WRITE_DISABLE = 1'b0;

endpackage

// File: rtl/dram_arb_pick.sv
// Combinational two-way picker producing a one-hot grant {m1, m0}.
// Latency: zero (pure combinational). Backpressure: a denied request simply
// gets no grant; the requester holds it until granted.
// Ports: req0/req1 requests, last_owner (round-robin history), in_lock
// (port 1 holds the RAM), force_m0 (starvation preemption), grant one-hot.
// Build option: DRAM_ARB_RR_EN selects round-robin IDLE arbitration,
// otherwise port 0 has fixed priority.
module dram_arb_pick
  import dram_arb_pkg::*;
(
  input  logic       req0,
  input  logic       req1,
  input  logic       last_owner,
  input  logic       in_lock,
  input  logic       force_m0,
  output logic [1:0] grant
);

`ifndef DRAM_ARB_RR_EN
  // History is kept by the top but ignored under fixed priority.
  logic unused_last_owner;
  assign unused_last_owner = last_owner;
`endif

  always_comb begin
    grant = 2'b00;
    if (force_m0) begin
      // Starvation bound reached: CPU gets exactly this cycle.
      grant = 2'b01;
    end else if (in_lock && req1) begin
      grant = 2'b10;
    end else if (req0 && req1) begin
`ifdef DRAM_ARB_RR_EN
      grant = (last_owner == OWNER_M0) ? 2'b10 : 2'b01;
`else
      grant = 2'b01;
`endif
    end else if (req0) begin
      grant = 2'b01;
    end else if (req1) begin
      grant = 2'b10;
    end
  end

endmodule

// File: rtl/data_ram_arbiter.sv
// Shares the single-port data_ram between the CPU MEM stage (port 0) and the
// DMA/boot-loader (port 1); port 1 may lock the RAM for bursts.
// Latency: zero; ack, RAM command and read data settle in the request cycle.
// Backpressure: a denied master sees ack=0 and holds its request; stall_o
// flags a waiting CPU. A lock starves the CPU at most MAX_WAIT cycles.
// Ports: clk/rst, m0_*/m1_* master request and response, m1_lock,
// stall_o to the pipeline, ram_* command and ram_rdata from data_ram.
// Build option: DRAM_ARB_RR_EN (round-robin IDLE arbitration, see picker).
module data_ram_arbiter
  import dram_arb_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic                clk,
  input  logic                rst,

  input  logic                m0_req,
  input  logic                m0_we,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic [DATA_W/8-1:0] m0_sel,
  input  logic [DATA_W-1:0]   m0_wdata,
  output logic                m0_ack,
  output logic [DATA_W-1:0]   m0_rdata,

  input  logic                m1_req,
  input  logic                m1_we,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [DATA_W/8-1:0] m1_sel,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic                m1_lock,
  output logic                m1_ack,
  output logic [DATA_W-1:0]   m1_rdata,

  output logic                stall_o,

  output logic                ram_ce,
  output logic                ram_we,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [DATA_W/8-1:0] ram_sel,
  output logic [DATA_W-1:0]   ram_wdata,
  input  logic [DATA_W-1:0]   ram_rdata
);

  localparam logic [WAIT_CNT_W-1:0] MAX_WAIT_C = WAIT_CNT_W'(MAX_WAIT);

  arb_state_t            state;
  logic                  last_owner;
  logic [WAIT_CNT_W-1:0] wait_cnt;

  logic       req0, req1;
  logic       force_m0;
  logic [1:0] grant;

  // Requests are masked during reset so every output reads 0 while rst=1.
  assign req0     = m0_req & ~rst;
  assign req1     = m1_req & ~rst;
  assign force_m0 = (state == LOCK1) && (wait_cnt == MAX_WAIT_C) && req0;

  dram_arb_pick u_pick (
    .req0       (req0),
    .req1       (req1),
    .last_owner (last_owner),
    .in_lock    (state == LOCK1),
    .force_m0   (force_m0),
    .grant      (grant)
  );

  assign m0_ack  = grant[0];
  assign m1_ack  = grant[1];
  assign stall_o = req0 & ~grant[0];

  always_comb begin
    ram_ce    = CHIP_DISABLE;
    ram_we    = WRITE_DISABLE;
    ram_addr  = '0;
    ram_sel   = '0;
    ram_wdata = '0;
    if (grant[0]) begin
      ram_ce    = CHIP_ENABLE;
      ram_we    = m0_we;
      ram_addr  = m0_addr;
      ram_sel   = m0_sel;
      ram_wdata = m0_wdata;
    end else if (grant[1]) begin
      ram_ce    = CHIP_ENABLE;
      ram_we    = m1_we;
      ram_addr  = m1_addr;
      ram_sel   = m1_sel;
      ram_wdata = m1_wdata;
    end
  end

  assign m0_rdata = (grant[0] && !m0_we) ? ram_rdata : '0;
  assign m1_rdata = (grant[1] && !m1_we) ? ram_rdata : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_owner <= OWNER_M1;
      wait_cnt   <= '0;
    end else begin
      case (state)
        IDLE:    if (grant[1] && m1_lock) state <= LOCK1;
        // Lock release wins even over a forced CPU cycle.
        LOCK1:   if (!m1_lock) state <= IDLE;
        default: state <= IDLE;
      endcase

      if (grant[0])      last_owner <= OWNER_M0;
      else if (grant[1]) last_owner <= OWNER_M1;

      // Clear has priority; otherwise count denied CPU cycles, saturating.
      if (!m0_req || grant[0])     wait_cnt <= '0;
      else if (wait_cnt < MAX_WAIT_C) wait_cnt <= wait_cnt + 1'b1;
    end
  end

endmodule
